// File: rtl/nibble_serial_adder_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_if
//
// Bundles the operand-side and result-side valid/ready handshakes of
// nibble_serial_adder into one interface.
//
// Signals:
//   in_valid  - producer presents operands
//   in_ready  - adder can accept operands
//   a, b      - WIDTH-bit operands
//   c_in      - carry-in
//   sub       - subtract request (exists only when NSA_SUB_EN is defined)
//   out_valid - result available
//   out_ready - consumer takes the result
//   sum       - WIDTH-bit result
//   c_out     - carry out of bit WIDTH-1
//   ovf       - two's-complement overflow
//
// Modports:
//   master - the producer/consumer side (drives operands and out_ready)
//   slave  - the adder side
//
// Configuration macro: NSA_SUB_EN adds the sub signal.
// -----------------------------------------------------------------------------
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef NSA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

`ifdef NSA_SUB_EN
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`endif

endinterface

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder. Operands are captured once, then one 4-bit
// ripple-carry slice processes a nibble per clock (LSB nibble first), with
// the inter-nibble carry held in a flip-flop. One operation is in flight at a
// time; both the operand and result sides use valid/ready handshakes.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (aborts any operation in flight)
//   bus  - nibble_serial_adder_if.slave:
//            in_valid/in_ready, a, b, c_in, [sub]   operand handshake
//            out_valid/out_ready, sum, c_out, ovf   result handshake
//
// Parameters:
//   WIDTH - operand/result width; a multiple of 4 and at least 4.
//
// Configuration macro:
//   NSA_SUB_EN - when defined, bus.sub = 1 turns the operation into a - b
//                (B is inverted and the carry-in forced to 1 at capture;
//                c_in is ignored). c_out = 1 then means "no borrow".
//
// Timing: accept on edge k, RUN on edges k+1..k+N, out_valid from edge k+N,
// with N = WIDTH/4. in_ready is a pure decode of the state.
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    nibble_serial_adder_if.slave bus
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               carry_q,  carry_d;
    logic               c_out_q,  c_out_d;
    logic               ovf_q,    ovf_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;

    logic               in_ready_c;
    logic               out_valid_c;

    // -------------------------------------------------------------------------
    // Nibble views of the operand registers
    // -------------------------------------------------------------------------
    logic [3:0] a_nib [N];
    logic [3:0] b_nib [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_nib
            assign a_nib[gi] = a_q[4*gi +: 4];
            assign b_nib[gi] = b_q[4*gi +: 4];
        end
    endgenerate

    // Nibble select as an AND-OR style loop so a non-power-of-two N never
    // indexes past the end of the array.
    logic [3:0] a_sel;
    logic [3:0] b_sel;

    always_comb begin
        a_sel = 4'h0;
        b_sel = 4'h0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sel = a_nib[i];
                b_sel = b_nib[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // The single 4-bit slice: bit 4 of the result is the slice carry-out.
    // -------------------------------------------------------------------------
    logic [4:0] slice_res;
    logic       last_nib;
    logic       run_step;
    logic       msb_carry_in;

    assign slice_res = {1'b0, a_sel} + {1'b0, b_sel} + {4'b0000, carry_q};
    assign last_nib  = (idx_q == IDX_W'(N - 1));
    assign run_step  = (state_q == RUN);

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin, so
    // cin = a ^ b ^ s. Only meaningful while the top nibble is in the slice.
    // b_q already holds the inverted operand for a subtract.
    assign msb_carry_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_res[3];

    // Each sum nibble is written only in the RUN cycle that selects it; the
    // rest hold, so IDLE keeps showing the previous result.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sum
            assign sum_d[4*gi +: 4] = (run_step && (idx_q == IDX_W'(gi)))
                                      ? slice_res[3:0]
                                      : sum_q[4*gi +: 4];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        idx_d       = idx_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    a_d   = bus.a;
                    idx_d = '0;
`ifdef NSA_SUB_EN
                    // a - b computed as a + ~b + 1.
                    if (bus.sub) begin
                        b_d     = ~bus.b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = bus.b;
                        carry_d = bus.c_in;
                    end
`else
                    b_d     = bus.b;
                    carry_d = bus.c_in;
`endif
                    state_d = RUN;
                end
            end

            RUN: begin
                carry_d = slice_res[4];
                idx_d   = idx_q + 1'b1;
                if (last_nib) begin
                    c_out_d = slice_res[4];
                    ovf_d   = slice_res[4] ^ msb_carry_in;
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Interface outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;

endmodule
